// File: rtl/array3d_index_ctrl.sv
// Subscript sequencer for a D0 x D1 x D2 element array: evaluates three
// pos-relative subscripts left to right, then reads the addressed element.
module array3d_index_ctrl #(
  parameter int D0 = 2,
  parameter int D1 = 3,
  parameter int D2 = 4,
  parameter int DW = 32,
  parameter int PW = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_gate,
  input  logic                                 cmd_pos_load,
  input  logic [PW-1:0]                        cmd_pos,
  input  logic [8:0]                           cmd_op,
  input  logic [3*PW-1:0]                      cmd_const,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [DW-1:0]                        rsp_data,
  output logic [PW-1:0]                        rsp_pos,
  output logic                                 rsp_err,
  input  logic                                 wr_en,
  input  logic [$clog2(D0*D1*D2)-1:0]          wr_addr,
  input  logic [DW-1:0]                        wr_data
);

  localparam int unsigned N  = D0 * D1 * D2;
  localparam int unsigned AW = $clog2(N);

  typedef enum logic [2:0] {IDLE, IDX0, IDX1, IDX2, READ, RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q;
  logic [8:0]       op_q;
  logic [3*PW-1:0]  const_q;
  logic [PW-1:0]    i0_q, i1_q, i2_q;
  logic             err_q;
  logic [DW-1:0]    mem [N];

  logic [2:0]       cur_op;
  logic [PW-1:0]    cur_const;
  logic [PW-1:0]    pos_n;
  logic [PW-1:0]    idx;
  int unsigned      dsize;
  logic             idx_oor;
  logic [AW-1:0]    rd_addr;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = cmd_gate ? IDX0 : RESP;
      IDX0: state_d = IDX1;
      IDX1: state_d = IDX2;
      IDX2: state_d = READ;
      READ: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the op/constant/dimension for the subscript being evaluated now.
  always_comb begin
    cur_op    = 3'b000;
    cur_const = '0;
    dsize     = 32'(D0);
    case (state_q)
      IDX0: begin cur_op = op_q[2:0]; cur_const = const_q[PW-1:0];      dsize = 32'(D0); end
      IDX1: begin cur_op = op_q[5:3]; cur_const = const_q[2*PW-1:PW];   dsize = 32'(D1); end
      IDX2: begin cur_op = op_q[8:6]; cur_const = const_q[3*PW-1:2*PW]; dsize = 32'(D2); end
      default: ;
    endcase
  end

  always_comb begin
    pos_n = pos_q;
    idx   = pos_q;
    case (cur_op)
      3'b001: pos_n = pos_q + 1'b1;
      3'b010: begin pos_n = pos_q + 1'b1; idx = pos_n; end
      3'b011: pos_n = pos_q - 1'b1;
      3'b100: begin pos_n = pos_q - 1'b1; idx = pos_n; end
      3'b101: idx = cur_const;
      default: ;
    endcase
  end

  assign idx_oor = idx[PW-1] || (32'(idx) >= dsize);

  // Only meaningful when all subscripts are in range, so truncation is safe.
  assign rd_addr = (AW'(i0_q) * AW'(D1) + AW'(i1_q)) * AW'(D2) + AW'(i2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q    <= '0;
      op_q     <= '0;
      const_q  <= '0;
      i0_q     <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      err_q    <= 1'b0;
      rsp_data <= '0;
      rsp_pos  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q    <= cmd_op;
          const_q <= cmd_const;
          err_q   <= 1'b0;
          if (cmd_pos_load) pos_q <= cmd_pos;
          if (!cmd_gate) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_pos  <= cmd_pos_load ? cmd_pos : pos_q;
          end
        end
        IDX0, IDX1, IDX2: begin
          pos_q <= pos_n;
          err_q <= err_q | idx_oor;
          if (state_q == IDX0) i0_q <= idx;
          if (state_q == IDX1) i1_q <= idx;
          if (state_q == IDX2) i2_q <= idx;
        end
        READ: begin
          rsp_data <= err_q ? '0 : mem[rd_addr];
          rsp_err  <= err_q;
          rsp_pos  <= pos_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) mem[k] <= DW'(k);
    end else if (wr_en && (32'(wr_addr) < N)) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_array3d_index_ctrl.sv
// Directed self-checking bench for array3d_index_ctrl.
module tb_array3d_index_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_gate, cmd_pos_load;
  logic [7:0]  cmd_pos;
  logic [8:0]  cmd_op;
  logic [23:0] cmd_const;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_pos;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] USE = 3'd0, POI = 3'd1, PRI = 3'd2, POD = 3'd3, PRD = 3'd4, CST = 3'd5;

  array3d_index_ctrl #(.D0(2), .D1(3), .D2(4), .DW(32), .PW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_gate(cmd_gate),
    .cmd_pos_load(cmd_pos_load), .cmd_pos(cmd_pos), .cmd_op(cmd_op), .cmd_const(cmd_const),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_pos(rsp_pos), .rsp_err(rsp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command; optionally write addr 7 during READ and hold rsp_ready low.
  task automatic run_cmd(input string tag, input logic gate, input logic load,
                         input logic [7:0] cpos, input logic [8:0] op, input logic [23:0] cc,
                         input logic [31:0] e_data, input logic [7:0] e_pos, input logic e_err,
                         input int e_lat, input logic wr_in_read, input int hold);
    int n;
    @(negedge clk);
    check({tag, ".ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_gate = gate; cmd_pos_load = load;
    cmd_pos = cpos; cmd_op = op; cmd_const = cc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      wr_en = wr_in_read && (n == 4);
      wr_addr = 5'd7; wr_data = 32'hDEAD;
      if (rsp_valid) break;
    end
    wr_en = 1'b0;
    check({tag, ".lat"},  n, e_lat);
    check({tag, ".data"}, rsp_data, e_data);
    check({tag, ".pos"},  rsp_pos, e_pos);
    check({tag, ".err"},  rsp_err, e_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, rsp_valid, 1);
      check({tag, ".hold_data"},  rsp_data, e_data);
      check({tag, ".hold_pos"},   rsp_pos, e_pos);
      check({tag, ".hold_ready"}, cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, ".done"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_gate = 1; cmd_pos_load = 0; cmd_pos = '0; cmd_op = '0; cmd_const = '0;
    rsp_ready = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst.ready", cmd_ready, 1);
    check("rst.valid", rsp_valid, 0);
    check("rst.data",  rsp_data, 0);
    check("rst.pos",   rsp_pos, 0);
    check("rst.err",   rsp_err, 0);
    rst = 1'b0;

    run_cmd("t1", 1, 1, 8'd0, {PRI, POI, POI}, 24'h0, 32'd7, 8'd3, 0, 5, 0, 0);
    run_cmd("t2", 1, 1, 8'd0, {PRI, CST, CST}, 24'h0, 32'd1, 8'd1, 0, 5, 0, 0);
    run_cmd("t2g", 0, 1, 8'd0, {PRI, CST, CST}, 24'h0, 32'd0, 8'd0, 0, 1, 0, 0);
    run_cmd("t3", 1, 1, 8'd3, {PRD, CST, CST}, {8'd0, 8'd2, 8'd1}, 32'd22, 8'd2, 0, 5, 0, 0);
    run_cmd("t3b", 1, 1, 8'd3, {POD, CST, CST}, {8'd0, 8'd2, 8'd1}, 32'd23, 8'd2, 0, 5, 0, 0);
    run_cmd("t4", 1, 1, 8'd0, {CST, CST, PRD}, 24'h0, 32'd0, 8'hFF, 1, 5, 0, 0);
    run_cmd("t4w", 1, 1, 8'h7F, {CST, CST, PRI}, 24'h0, 32'd0, 8'h80, 1, 5, 0, 0);
    run_cmd("t5", 1, 1, 8'd0, {PRI, POI, POI}, 24'h0, 32'd7, 8'd3, 0, 5, 1, 0);
    run_cmd("t5b", 1, 1, 8'd0, {PRI, POI, POI}, 24'h0, 32'hDEAD, 8'd3, 0, 5, 0, 0);
    run_cmd("t6", 1, 1, 8'd0, {PRI, CST, CST}, 24'h0, 32'd1, 8'd1, 0, 5, 0, 4);

    // Abort a command in IDX1 with reset.
    @(negedge clk);
    cmd_valid = 1; cmd_gate = 1; cmd_pos_load = 1; cmd_pos = 8'd5;
    cmd_op = {POI, POI, POI}; cmd_const = '0;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort.valid", rsp_valid, 0);
    end
    check("abort.ready", cmd_ready, 1);
    check("abort.pos", rsp_pos, 0);
    run_cmd("t7", 1, 0, 8'd0, {USE, POI, POI}, 24'h0, 32'd6, 8'd2, 0, 5, 0, 0);
    run_cmd("t7b", 1, 1, 8'd0, {PRI, POI, POI}, 24'h0, 32'd7, 8'd3, 0, 5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
